// File: rtl/hazard_scoreboard_ctrl.sv
// Decode-to-execute issue controller: RAW/WAW scoreboard, accelerator serialisation,
// mispredict flush sequencing and perf counters. Optional macro: HZ_WB_BYPASS_EN.
module hazard_scoreboard_ctrl #(
  parameter int NUM_REGS     = 8,
  parameter int REG_W        = 3,
  parameter int OP_W         = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int ACC_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [OP_W-1:0]     id_opcode,
  input  logic [REG_W-1:0]    id_rd,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_rd,
  input  logic                acc_done,
  input  logic                ex_br_valid,
  input  logic                ex_br_taken,
  input  logic                ex_br_pred_taken,
  output logic                issue,
  output logic                stall,
  output logic                flush,
  output logic [NUM_REGS-1:0] pending,
  output logic                acc_busy,
  output logic                acc_timeout,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    mispredict_cnt
);

  localparam logic [OP_W-1:0] OP_NOP    = OP_W'(5'b00000);
  localparam logic [OP_W-1:0] OP_HALT   = OP_W'(5'b11111);
  localparam logic [OP_W-1:0] OP_BR0    = OP_W'(5'b01010);
  localparam logic [OP_W-1:0] OP_BR1    = OP_W'(5'b01011);
  localparam logic [OP_W-1:0] OP_BR2    = OP_W'(5'b01100);
  localparam logic [OP_W-1:0] OP_FFT    = OP_W'(5'b01101);
  localparam logic [OP_W-1:0] OP_CRYPTO = OP_W'(5'b01110);

  localparam int              WD_W      = $clog2(ACC_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX    = WD_W'(ACC_TIMEOUT);
  localparam logic [WD_W-1:0] WD_PRE    = WD_W'(ACC_TIMEOUT - 1);
  localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] { RUN = 1'b0, FLUSH = 1'b1 } state_t;

  state_t          state, state_nxt;
  logic [2:0]      flush_cnt, flush_cnt_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic            mispredict_evt;

  logic is_branch, is_idle_op, is_acc, reads, writes;
  logic rs1_busy, rs2_busy, rd_busy;
  logic raw, waw, struct_hz, hazard;

  assign is_branch  = (id_opcode == OP_BR0) || (id_opcode == OP_BR1) || (id_opcode == OP_BR2);
  assign is_idle_op = (id_opcode == OP_NOP) || (id_opcode == OP_HALT);
  assign is_acc     = (id_opcode == OP_FFT) || (id_opcode == OP_CRYPTO);
  assign reads      = ~is_idle_op;
  assign writes     = ~is_idle_op & ~is_branch;

`ifdef HZ_WB_BYPASS_EN
  // A retiring writeback releases its dependents in the same cycle.
  assign rs1_busy = pending[id_rs1] & ~(wb_valid & (wb_rd == id_rs1));
  assign rs2_busy = pending[id_rs2] & ~(wb_valid & (wb_rd == id_rs2));
  assign rd_busy  = pending[id_rd]  & ~(wb_valid & (wb_rd == id_rd));
`else
  assign rs1_busy = pending[id_rs1];
  assign rs2_busy = pending[id_rs2];
  assign rd_busy  = pending[id_rd];
`endif

  assign raw       = reads & (rs1_busy | rs2_busy);
  assign waw       = writes & rd_busy;
  assign struct_hz = is_acc & acc_busy;
  assign hazard    = id_valid & (raw | waw | struct_hz);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    flush_cnt_nxt  = flush_cnt;
    issue          = 1'b0;
    stall          = 1'b0;
    flush          = 1'b0;
    mispredict_evt = 1'b0;
    case (state)
      RUN: begin
        mispredict_evt = ex_br_valid & (ex_br_taken != ex_br_pred_taken);
        if (mispredict_evt) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FLUSH_INIT;
        end else begin
          issue = id_valid & ~hazard;
        end
        stall = hazard & ~mispredict_evt;
      end
      FLUSH: begin
        flush = 1'b1;
        if (flush_cnt == 3'd0) state_nxt = RUN;
        else                   flush_cnt_nxt = flush_cnt - 3'd1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Clear before set so a same-index writeback and issue leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (issue && writes && (id_rd == REG_W'(i)))
          pending[i] <= 1'b1;
        else if (wb_valid && (wb_rd == REG_W'(i)))
          pending[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_busy    <= 1'b0;
      wd_cnt      <= '0;
      acc_timeout <= 1'b0;
    end else begin
      if (issue && is_acc) acc_busy <= 1'b1;
      else if (acc_done)   acc_busy <= 1'b0;

      if (!acc_busy)            wd_cnt <= '0;
      else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;

      if (acc_busy && (wd_cnt == WD_PRE)) acc_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt      <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))               stall_cnt      <= stall_cnt + 1'b1;
      if (mispredict_evt && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench for hazard_scoreboard_ctrl; expected values are hand-derived per build
// (HZ_WB_BYPASS_EN selects the bypass expectations).
module tb_hazard_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_opcode;
  logic [2:0]  id_rd, id_rs1, id_rs2;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic        acc_done;
  logic        ex_br_valid, ex_br_taken, ex_br_pred_taken;
  logic        issue, stall, flush;
  logic [7:0]  pending;
  logic        acc_busy, acc_timeout;
  logic [15:0] stall_cnt, mispredict_cnt;

  int vectors = 0;
  int miscompares = 0;
  int exp_stall = 0;
  int exp_mp = 0;

  localparam logic [4:0] ADD = 5'b00001, NOP = 5'b00000, HALT = 5'b11111;
  localparam logic [4:0] BR = 5'b01011, FFT = 5'b01101, CRYPTO = 5'b01110;

  always #5 clk = ~clk;

  hazard_scoreboard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .acc_done(acc_done),
    .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken), .ex_br_pred_taken(ex_br_pred_taken),
    .issue(issue), .stall(stall), .flush(flush), .pending(pending),
    .acc_busy(acc_busy), .acc_timeout(acc_timeout),
    .stall_cnt(stall_cnt), .mispredict_cnt(mispredict_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_opcode = NOP; id_rd = 3'd0; id_rs1 = 3'd0; id_rs2 = 3'd0;
    wb_valid = 1'b0; wb_rd = 3'd0; acc_done = 1'b0;
    ex_br_valid = 1'b0; ex_br_taken = 1'b0; ex_br_pred_taken = 1'b0;
  endtask

  task automatic drive_id(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2);
    id_valid = 1'b1; id_opcode = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic branch(input logic v, input logic taken, input logic pred);
    ex_br_valid = v; ex_br_taken = taken; ex_br_pred_taken = pred;
  endtask

  // Checks the combinational decision for the current inputs, then clocks once.
  task automatic exp_cycle(input string tag, input logic ei, input logic es, input logic ef);
    #1;
    check_val({tag, ".issue"}, 32'(issue), 32'(ei));
    check_val({tag, ".stall"}, 32'(stall), 32'(es));
    check_val({tag, ".flush"}, 32'(flush), 32'(ef));
    if (es) exp_stall++;
    tick();
  endtask

  task automatic wb(input logic [2:0] rd);
    wb_valid = 1'b1; wb_rd = rd;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check_val("rst.pending", 32'(pending), 32'h0);
    check_val("rst.acc_busy", 32'(acc_busy), 32'h0);
    check_val("rst.timeout", 32'(acc_timeout), 32'h0);
    check_val("rst.stall_cnt", 32'(stall_cnt), 32'h0);
    check_val("rst.mp_cnt", 32'(mispredict_cnt), 32'h0);
    exp_cycle("rst.idle", 1'b0, 1'b0, 1'b0);

    // RAW on rs1 with late writeback
    drive_id(ADD, 3'd3, 3'd0, 3'd0);
    exp_cycle("raw.producer", 1'b1, 1'b0, 1'b0);
    check_val("raw.pend3", 32'(pending), 32'h08);
    drive_id(ADD, 3'd6, 3'd3, 3'd1);
    for (int i = 1; i <= 3; i++) exp_cycle("raw.wait", 1'b0, 1'b1, 1'b0);
    wb_valid = 1'b1; wb_rd = 3'd3;
`ifdef HZ_WB_BYPASS_EN
    exp_cycle("raw.wb_cyc", 1'b1, 1'b0, 1'b0);
    wb_valid = 1'b0; id_valid = 1'b0;
    check_val("raw.stall_cnt", 32'(stall_cnt), 32'd3);
`else
    exp_cycle("raw.wb_cyc", 1'b0, 1'b1, 1'b0);
    wb_valid = 1'b0;
    exp_cycle("raw.release", 1'b1, 1'b0, 1'b0);
    id_valid = 1'b0;
    check_val("raw.stall_cnt", 32'(stall_cnt), 32'd4);
`endif
    check_val("raw.pend6", 32'(pending), 32'h40);
    wb(3'd6);
    check_val("raw.cleared", 32'(pending), 32'h0);

    // WAW, rs2 RAW, non-reading/non-writing opcodes, set-wins
    drive_id(ADD, 3'd5, 3'd0, 3'd0);
    exp_cycle("waw.producer", 1'b1, 1'b0, 1'b0);
    drive_id(ADD, 3'd5, 3'd0, 3'd0);
    exp_cycle("waw.same_rd", 1'b0, 1'b1, 1'b0);
    drive_id(ADD, 3'd1, 3'd0, 3'd5);
    exp_cycle("raw.rs2", 1'b0, 1'b1, 1'b0);
    drive_id(NOP, 3'd5, 3'd5, 3'd5);
    exp_cycle("nop.free", 1'b1, 1'b0, 1'b0);
    drive_id(HALT, 3'd5, 3'd5, 3'd5);
    exp_cycle("halt.free", 1'b1, 1'b0, 1'b0);
    drive_id(BR, 3'd5, 3'd0, 3'd0);
    exp_cycle("br.no_waw", 1'b1, 1'b0, 1'b0);
    drive_id(BR, 3'd4, 3'd0, 3'd0);
    exp_cycle("br.rd4", 1'b1, 1'b0, 1'b0);
    check_val("br.no_write", 32'(pending), 32'h20);
    drive_id(BR, 3'd0, 3'd5, 3'd0);
    exp_cycle("br.reads", 1'b0, 1'b1, 1'b0);
    drive_id(ADD, 3'd5, 3'd0, 3'd0);
    wb_valid = 1'b1; wb_rd = 3'd5;
`ifdef HZ_WB_BYPASS_EN
    exp_cycle("setwins.cyc", 1'b1, 1'b0, 1'b0);
    check_val("setwins.pend", 32'(pending), 32'h20);
`else
    exp_cycle("setwins.cyc", 1'b0, 1'b1, 1'b0);
    check_val("setwins.pend", 32'(pending), 32'h00);
`endif
    idle();
    wb(3'd5);
    check_val("wb.noop_or_clear", 32'(pending), 32'h0);
    check_val("mix.stall_cnt", 32'(stall_cnt), 32'(exp_stall));

    // Accelerator serialisation
    drive_id(FFT, 3'd2, 3'd0, 3'd0);
    exp_cycle("acc.fft", 1'b1, 1'b0, 1'b0);
    check_val("acc.busy", 32'(acc_busy), 32'h1);
    check_val("acc.pend2", 32'(pending), 32'h04);
    drive_id(CRYPTO, 3'd5, 3'd0, 3'd0);
    exp_cycle("acc.struct1", 1'b0, 1'b1, 1'b0);
    exp_cycle("acc.struct2", 1'b0, 1'b1, 1'b0);
    acc_done = 1'b1;
    exp_cycle("acc.done_cyc", 1'b0, 1'b1, 1'b0);
    acc_done = 1'b0;
    check_val("acc.freed", 32'(acc_busy), 32'h0);
    check_val("acc.pend2_held", 32'(pending), 32'h04);
    exp_cycle("acc.crypto", 1'b1, 1'b0, 1'b0);
    id_valid = 1'b0;
    check_val("acc.busy2", 32'(acc_busy), 32'h1);
    check_val("acc.pend25", 32'(pending), 32'h24);
    acc_done = 1'b1; tick(); acc_done = 1'b0;
    wb(3'd2); wb(3'd5);
    check_val("acc.drained", 32'(pending), 32'h0);

    // Watchdog: boundary at 254 / 255 busy cycles
    drive_id(FFT, 3'd1, 3'd0, 3'd0);
    exp_cycle("wd.fft", 1'b1, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 254; i++) tick();
    check_val("wd.before", 32'(acc_timeout), 32'h0);
    tick();
    check_val("wd.fired", 32'(acc_timeout), 32'h1);
    acc_done = 1'b1; tick(); acc_done = 1'b0;
    tick();
    check_val("wd.done_busy", 32'(acc_busy), 32'h0);
    check_val("wd.sticky", 32'(acc_timeout), 32'h1);
    wb(3'd1);

    // Branch mispredict flush
    drive_id(ADD, 3'd7, 3'd0, 3'd0);
    branch(1'b1, 1'b1, 1'b0);
    exp_cycle("mp.cyc", 1'b0, 1'b0, 1'b0);
    exp_mp++;
    branch(1'b1, 1'b0, 1'b1);
    exp_cycle("mp.flush1", 1'b0, 1'b0, 1'b1);
    branch(1'b0, 1'b0, 1'b0);
    exp_cycle("mp.flush2", 1'b0, 1'b0, 1'b1);
    exp_cycle("mp.resume", 1'b1, 1'b0, 1'b0);
    check_val("mp.cnt1", 32'(mispredict_cnt), 32'(exp_mp));
    drive_id(ADD, 3'd6, 3'd0, 3'd0);
    branch(1'b1, 1'b1, 1'b1);
    exp_cycle("bp.correct", 1'b1, 1'b0, 1'b0);
    idle();
    exp_cycle("bp.no_flush", 1'b0, 1'b0, 1'b0);
    check_val("bp.pend", 32'(pending), 32'hC0);
    drive_id(ADD, 3'd1, 3'd7, 3'd0);
    branch(1'b1, 1'b0, 1'b1);
    exp_cycle("mp.hazard", 1'b0, 1'b0, 1'b0);
    exp_mp++;
    idle();
    exp_cycle("mp2.flush1", 1'b0, 1'b0, 1'b1);
    exp_cycle("mp2.flush2", 1'b0, 1'b0, 1'b1);
    exp_cycle("mp2.run", 1'b0, 1'b0, 1'b0);
    check_val("mp.cnt2", 32'(mispredict_cnt), 32'(exp_mp));
    check_val("mp.stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    wb(3'd7); wb(3'd6);

    // Reset during FLUSH with a full scoreboard
    for (int i = 0; i < 8; i++) begin
      drive_id(ADD, 3'(i), 3'(i), 3'(i));
      exp_cycle("fill", 1'b1, 1'b0, 1'b0);
    end
    idle();
    check_val("fill.pend", 32'(pending), 32'hFF);
    branch(1'b1, 1'b1, 1'b0);
    exp_cycle("rf.mp", 1'b0, 1'b0, 1'b0);
    branch(1'b0, 1'b0, 1'b0);
    #1;
    check_val("rf.in_flush", 32'(flush), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_stall = 0;
    check_val("rf.pending", 32'(pending), 32'h0);
    check_val("rf.timeout", 32'(acc_timeout), 32'h0);
    check_val("rf.mp_cnt", 32'(mispredict_cnt), 32'h0);
    check_val("rf.stall_cnt", 32'(stall_cnt), 32'h0);
    drive_id(ADD, 3'd3, 3'd3, 3'd0);
    exp_cycle("rf.issue", 1'b1, 1'b0, 1'b0);
    idle();
    check_val("rf.pend3", 32'(pending), 32'h08);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
